// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch/halt decode with optional return stack.
// Define PC_SEQUENCER_STACK_EN to build CALL/RET support and the FAULT path.
module pc_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int INST_W    = 8,
  parameter int OFF_W     = 4,
  parameter int STK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INST_W-1:0]              inst,
  input  logic [3:0]                     flags,
  input  logic                           addr_lock,
  input  logic                           resume,
  output logic [ADDR_W-1:0]              pc,
  output logic                           halted,
  output logic                           fault,
  output logic [$clog2(STK_DEPTH+1)-1:0] stk_level
);

  localparam int LVL_W = $clog2(STK_DEPTH+1);

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

  typedef struct packed {
    logic [3:0]        opc;
    logic [ADDR_W-1:0] off;
    logic              halt;
  } dec_t;

  state_t             state;
  dec_t               dec;
  logic signed [OFF_W-1:0] off_s;
  logic [ADDR_W-1:0]  pc_inc, pc_tgt;
  logic               br_taken;

  assign off_s    = inst[OFF_W-1:0];
  assign dec.opc  = inst[INST_W-1 -: 4];
  assign dec.off  = ADDR_W'(off_s);
  assign dec.halt = (inst == {4'h3, {(INST_W-4){1'b1}}});
  assign pc_inc   = pc + ADDR_W'(1);
  assign pc_tgt   = pc + dec.off;
  assign br_taken = flags[dec.opc[1:0]];

`ifdef PC_SEQUENCER_STACK_EN
  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [ADDR_W-1:0] stk [STK_DEPTH];
  logic [LVL_W-1:0]  stk_lvl;
  logic              run_go, is_call, is_ret, stk_full, stk_empty, push;

  assign run_go    = (state == RUN) && !addr_lock && !dec.halt;
  assign is_call   = run_go && (dec.opc == 4'hB);
  assign is_ret    = run_go && (dec.opc == 4'hA) && (inst[OFF_W-1:0] == '0);
  assign stk_full  = (stk_lvl == LVL_W'(STK_DEPTH));
  assign stk_empty = (stk_lvl == '0);
  assign push      = is_call && !stk_full;
  assign stk_level = stk_lvl;

  // Stack payload carries no reset; only the level counter defines validity.
  always_ff @(posedge clk) begin
    if (push) stk[IDX_W'(stk_lvl)] <= pc_inc;
  end
`else
  assign stk_level = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      state  <= RUN;
      halted <= 1'b0;
      fault  <= 1'b0;
`ifdef PC_SEQUENCER_STACK_EN
      stk_lvl <= '0;
`endif
    end else begin
      case (state)
        RUN: if (!addr_lock) begin
          if (dec.halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (dec.opc[3:2] == 2'b11) begin
            pc <= br_taken ? pc_tgt : pc_inc;
`ifdef PC_SEQUENCER_STACK_EN
          end else if (is_call) begin
            if (stk_full) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              pc      <= pc_tgt;
              stk_lvl <= stk_lvl + LVL_W'(1);
            end
          end else if (is_ret) begin
            if (stk_empty) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              pc      <= stk[IDX_W'(stk_lvl - LVL_W'(1))];
              stk_lvl <= stk_lvl - LVL_W'(1);
            end
`endif
          end else begin
            pc <= pc_inc;
          end
        end
        HALTED: if (resume && !addr_lock) begin
          pc     <= pc_inc;
          state  <= RUN;
          halted <= 1'b0;
        end
        default: ; // FAULT holds until reset
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, stack corner sequences,
// then randomized traffic against a queue-based behavioural model.
module tb_pc_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inst = '0;
  logic [3:0] flags = '0;
  logic       addr_lock = 1'b0, resume = 1'b0;
  logic [7:0] pc;
  logic       halted, fault;
  logic [2:0] stk_level;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .inst(inst), .flags(flags), .addr_lock(addr_lock),
    .resume(resume), .pc(pc), .halted(halted), .fault(fault), .stk_level(stk_level)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0=run 1=halted 2=fault, stack as a queue.
  int m_pc, m_st;
  int m_stk[$];

  function automatic void m_reset();
    m_pc = 0; m_st = 0; m_stk.delete();
  endfunction

  function automatic void m_step(logic [7:0] i, logic [3:0] f, logic lk, logic rs);
    int opc, off;
    opc = i[7:4];
    off = (i[3:0] >= 8) ? int'(i[3:0]) - 16 : int'(i[3:0]);
    if (m_st == 0 && !lk) begin
      if (i == 8'h3F) m_st = 1;
      else if (opc >= 12) m_pc = f[opc-12] ? m_pc + off : m_pc + 1;
`ifdef PC_SEQUENCER_STACK_EN
      else if (opc == 11) begin
        if (m_stk.size() == DEPTH) m_st = 2;
        else begin m_stk.push_back((m_pc + 1) % 256); m_pc = m_pc + off; end
      end else if (opc == 10 && off == 0) begin
        if (m_stk.size() == 0) m_st = 2;
        else m_pc = m_stk.pop_back();
      end
`endif
      else m_pc = m_pc + 1;
    end else if (m_st == 1 && rs && !lk) begin
      m_pc = m_pc + 1; m_st = 0;
    end
    m_pc = ((m_pc % 256) + 256) % 256;
  endfunction

  task automatic cmp_model(string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".halted"}, halted, m_st == 1);
    chk({tag, ".fault"}, fault, m_st == 2);
    chk({tag, ".lvl"}, stk_level, m_stk.size());
  endtask

  // One clock: drive, advance model, sample 1ns after the edge.
  task automatic cyc(logic [7:0] i, logic [3:0] f, logic lk, logic rs);
    inst = i; flags = f; addr_lock = lk; resume = rs;
    m_step(i, f, lk, rs);
    @(posedge clk); #1;
  endtask

  // Reset is checked before any clock edge to prove it is asynchronous.
  task automatic do_reset();
    rst = 1'b1; #1;
    chk("rst.pc", pc, 0);
    chk("rst.halted", halted, 0);
    chk("rst.fault", fault, 0);
    chk("rst.lvl", stk_level, 0);
    @(posedge clk); #1;
    rst = 1'b0; resume = 1'b0; addr_lock = 1'b0;
    m_reset();
  endtask

  typedef struct {
    bit         rs;
    logic [7:0] i;
    logic [3:0] f;
    bit         lk, re;
    logic [7:0] pc;
    bit         h;
  } vec_t;

  function automatic vec_t mk(bit rs, logic [7:0] i, logic [3:0] f, bit lk, bit re,
                              logic [7:0] p, bit h);
    vec_t v;
    v.rs = rs; v.i = i; v.f = f; v.lk = lk; v.re = re; v.pc = p; v.h = h;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(1, 8'h00, 4'h0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'hC7, 4'h1, 0, 0, 8'h07, 0));
    tbl.push_back(mk(0, 8'hC7, 4'h1, 0, 0, 8'h0E, 0));
    tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'h0F, 0));
    tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'h10, 0));
    tbl.push_back(mk(0, 8'hC3, 4'h1, 0, 0, 8'h13, 0)); // taken +3
    tbl.push_back(mk(0, 8'hCD, 4'h1, 0, 0, 8'h10, 0)); // back -3
    tbl.push_back(mk(0, 8'hC3, 4'h0, 0, 0, 8'h11, 0)); // not taken
    tbl.push_back(mk(0, 8'hD5, 4'h2, 0, 0, 8'h16, 0));
    tbl.push_back(mk(0, 8'hF5, 4'h7, 0, 0, 8'h17, 0)); // flags[3]=0
    tbl.push_back(mk(0, 8'hF0, 4'h8, 0, 0, 8'h17, 0)); // self-loop
    tbl.push_back(mk(1, 8'h00, 4'h0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'h01, 0));
    tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'h02, 0));
    tbl.push_back(mk(0, 8'hEC, 4'h4, 0, 0, 8'hFE, 0)); // negative wrap
    tbl.push_back(mk(0, 8'h00, 4'h0, 1, 0, 8'hFE, 0));
    tbl.push_back(mk(0, 8'h3F, 4'h0, 1, 0, 8'hFE, 0)); // lock blocks halt
    tbl.push_back(mk(0, 8'hEC, 4'h4, 1, 0, 8'hFE, 0));
    tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'hFF, 0));
    tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'h00, 0)); // increment wrap
    tbl.push_back(mk(0, 8'hC7, 4'h1, 0, 0, 8'h07, 0));
    tbl.push_back(mk(0, 8'hC7, 4'h1, 0, 0, 8'h0E, 0));
    tbl.push_back(mk(0, 8'hC7, 4'h1, 0, 0, 8'h15, 0));
    tbl.push_back(mk(0, 8'hC7, 4'h1, 0, 0, 8'h1C, 0));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'h1C + k[7:0], 0));
    tbl.push_back(mk(0, 8'h3F, 4'h0, 0, 0, 8'h20, 1)); // halt
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 8'h00, 4'h0, 0, 0, 8'h20, 1));
    tbl.push_back(mk(0, 8'h00, 4'h0, 1, 1, 8'h20, 1)); // resume under lock ignored
    tbl.push_back(mk(0, 8'h00, 4'h0, 0, 1, 8'h21, 0));
    tbl.push_back(mk(0, 8'h3E, 4'h0, 0, 0, 8'h22, 0)); // near-halt encodings
    tbl.push_back(mk(0, 8'h7F, 4'h0, 0, 0, 8'h23, 0));

    #1;
    foreach (tbl[n]) begin
      if (tbl[n].rs) do_reset();
      else cyc(tbl[n].i, tbl[n].f, tbl[n].lk, tbl[n].re);
      chk($sformatf("vec%0d.pc", n), pc, tbl[n].pc);
      chk($sformatf("vec%0d.halted", n), halted, tbl[n].h);
      chk($sformatf("vec%0d.fault", n), fault, 0);
      chk($sformatf("vec%0d.lvl", n), stk_level, 0);
    end

    // Async reset while halted, between clock edges.
    cyc(8'h3F, 4'h0, 0, 0);
    chk("halt2.halted", halted, 1);
    #2 do_reset();

`ifdef PC_SEQUENCER_STACK_EN
    for (int k = 0; k < 9; k++) cyc(8'hC7, 4'h1, 0, 0);
    cyc(8'h00, 4'h0, 0, 0);
    chk("call.start", pc, 8'h40);
    cyc(8'hB5, 4'h0, 0, 0);
    chk("call.pc", pc, 8'h45); chk("call.lvl", stk_level, 1);
    cyc(8'hB5, 4'h0, 1, 0);
    chk("call.lock.pc", pc, 8'h45); chk("call.lock.lvl", stk_level, 1);
    cyc(8'hA1, 4'h0, 0, 0);
    chk("a1.pc", pc, 8'h46); chk("a1.lvl", stk_level, 1);
    cyc(8'hA0, 4'h0, 0, 0);
    chk("ret.pc", pc, 8'h41); chk("ret.lvl", stk_level, 0);
    cyc(8'hA0, 4'h0, 0, 0);
    chk("ret0.fault", fault, 1); chk("ret0.pc", pc, 8'h41);
    for (int k = 0; k < 3; k++) cyc(8'hC3, 4'hF, 0, 1);
    chk("fault.hold.pc", pc, 8'h41); chk("fault.hold", fault, 1);
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cyc(8'hB1, 4'h0, 0, 0);
      cmp_model($sformatf("call%0d", k));
    end
    chk("ovf.fault", fault, 1); chk("ovf.lvl", stk_level, 4); chk("ovf.pc", pc, 8'h04);
    #2 do_reset();
`else
    cyc(8'hB5, 4'h0, 0, 0);
    chk("nostk.b.pc", pc, 8'h01); chk("nostk.b.lvl", stk_level, 0);
    cyc(8'hA0, 4'h0, 0, 0);
    chk("nostk.a.pc", pc, 8'h02); chk("nostk.a.fault", fault, 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] ri;
      if ($urandom_range(0, 199) == 0 || (m_st == 2 && $urandom_range(0, 9) == 0)) do_reset();
      r = $urandom_range(0, 9);
      ri = (r == 0) ? 8'h3F : (r == 1) ? 8'hA0 : 8'($urandom);
      cyc(ri, 4'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
      cmp_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
